// File: rtl/csa_dot_accum.sv
// csa_dot_accum: carry-save dot-product accumulator with a segmented multi-cycle resolve adder
module csa_dot_accum #(
  parameter int IN_W  = 18,
  parameter int ACC_W = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_s,
  input  logic [IN_W-1:0]  in_c,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);
  localparam int NSEG = ACC_W / SEG_W;
  localparam int SB = NSEG > 1 ? $clog2(NSEG) : 1;
  typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d, res_q, res_d, sum_q, sum_d;
  logic [ACC_W-1:0] s, c, x, y;
  logic [SB-1:0] seg_q, seg_d;
  logic cy_q, cy_d;
  logic [SEG_W:0] seg_sum;
  assign in_ready = state_q == ACC;
  assign out_valid = state_q == DONE;
  assign out_sum = sum_q;
  always_comb begin
    s = ACC_W'(in_s);
    c = ACC_W'(in_c);
    x = acc_s_q ^ acc_c_q ^ s;
    y = ((acc_s_q & acc_c_q) | (acc_s_q & s) | (acc_c_q & s)) << 1;
    seg_sum = {1'b0, acc_s_q[seg_q*SEG_W +: SEG_W]} + {1'b0, acc_c_q[seg_q*SEG_W +: SEG_W]} + {{SEG_W{1'b0}}, cy_q};
    state_d = state_q;
    acc_s_d = acc_s_q;
    acc_c_d = acc_c_q;
    res_d = res_q;
    sum_d = sum_q;
    seg_d = seg_q;
    cy_d = cy_q;
    if (state_q == ACC && in_valid) begin
      acc_s_d = x ^ y ^ c;
      acc_c_d = ((x & y) | (x & c) | (y & c)) << 1;
      state_d = in_last ? RESOLVE : ACC;
      seg_d = in_last ? '0 : seg_q;
      cy_d = in_last ? 1'b0 : cy_q;
    end else if (state_q == RESOLVE) begin
      res_d[seg_q*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
      cy_d = seg_sum[SEG_W];
      seg_d = seg_q + 1'b1;
      if (seg_q == SB'(NSEG - 1)) begin
        state_d = DONE;
        sum_d = res_d;
      end
    end else if (state_q == DONE && out_ready) begin
      acc_s_d = '0;
      acc_c_d = '0;
      seg_d = '0;
      cy_d = 1'b0;
      state_d = ACC;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_s_q <= '0;
      acc_c_q <= '0;
      res_q <= '0;
      sum_q <= '0;
      seg_q <= '0;
      cy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_s_q <= acc_s_d;
      acc_c_q <= acc_c_d;
      res_q <= res_d;
      sum_q <= sum_d;
      seg_q <= seg_d;
      cy_q <= cy_d;
    end
  end
endmodule

// File: tb/tb_csa_dot_accum.sv
// tb_csa_dot_accum: scoreboard bench for csa_dot_accum with default and 20/4 configurations
module tb_csa_dot_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_ready, in_last, out_valid, out_ready;
  logic [17:0] in_s, in_c;
  logic [31:0] out_sum;
  logic v1, r1, l1, ov1, or1;
  logic [17:0] s1, c1;
  logic [19:0] o1;
  int tests = 0;
  int fails = 0;
  logic [31:0] q0[$];
  logic [19:0] q1[$];
  csa_dot_accum u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s), .in_c(in_c),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );
  csa_dot_accum #(.IN_W(18), .ACC_W(20), .SEG_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_s(s1), .in_c(c1),
    .in_last(l1), .out_valid(ov1), .out_ready(or1), .out_sum(o1)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u0_extra_result: got %0h expected none", out_sum);
      end else check("u0_out_sum", 64'(out_sum), 64'(q0.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (ov1 && or1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u1_extra_result: got %0h expected none", o1);
      end else check("u1_out_sum", 64'(o1), 64'(q1.pop_front()));
    end
  end
  task automatic beat0(input logic [17:0] s, input logic [17:0] c, input logic last);
    in_valid = 1'b1;
    in_s = s;
    in_c = c;
    in_last = last;
    check("u0_in_ready_beat", 64'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait0(input string name, input int lat);
    int n = 0;
    while (!out_valid && n < 30) begin
      check("u0_in_ready_busy", 64'(in_ready), 0);
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 64'(n + 1), 64'(lat));
  endtask
  task automatic take0();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("u0_in_ready_after_take", 64'(in_ready), 1);
    check("u0_out_valid_after_take", 64'(out_valid), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    in_valid = 0; in_last = 0; in_s = 0; in_c = 0; out_ready = 1;
    v1 = 0; l1 = 0; s1 = 0; c1 = 0; or1 = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_sum", 64'(out_sum), 0);
    check("rst_u1_in_ready", 64'(r1), 1);
    q0.push_back(32'd11);
    beat0(18'd5, 18'd6, 1'b1);
    wait0("single", 5);
    take0();
    q0.push_back(32'h001F_FFF8);
    for (int i = 0; i < 4; i++) beat0(18'h3FFFF, 18'h3FFFF, i == 3);
    wait0("four_beats", 5);
    take0();
    q0.push_back(32'h100);
    beat0(18'hFF, 18'h01, 1'b1);
    wait0("seg_carry", 5);
    take0();
    q0.push_back(32'h7FFFE);
    beat0(18'h3FFFF, 18'h3FFFF, 1'b1);
    wait0("max_beat", 5);
    take0();
    out_ready = 1'b0;
    q0.push_back(32'h1244);
    beat0(18'h1234, 18'h10, 1'b1);
    wait0("backpressure", 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_s = 18'(i + 1);
      in_c = 18'd1;
      in_last = 1'b1;
      @(posedge clk);
      #1;
      check("bp_out_valid", 64'(out_valid), 1);
      check("bp_out_sum", 64'(out_sum), 64'h1244);
      check("bp_in_ready", 64'(in_ready), 0);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    take0();
    q0.push_back(32'd5);
    beat0(18'd2, 18'd3, 1'b1);
    wait0("after_bp", 5);
    take0();
    beat0(18'd7, 18'd0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_in_ready", 64'(in_ready), 1);
    check("mid_rst_out_sum", 64'(out_sum), 0);
    q0.push_back(32'd3);
    beat0(18'd1, 18'd2, 1'b1);
    wait0("after_rst", 5);
    take0();
    q1.push_back(20'h7FFFA);
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b1;
      s1 = 18'h3FFFF;
      c1 = 18'h3FFFF;
      l1 = i == 2;
      check("u1_in_ready_beat", 64'(r1), 1);
      @(posedge clk);
      #1;
    end
    v1 = 1'b0;
    l1 = 1'b0;
    begin
      int n = 0;
      while (!ov1 && n < 30) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("u1_wrap_latency", 64'(n + 1), 6);
    end
    @(posedge clk);
    #1;
    check("u1_in_ready_after_take", 64'(r1), 1);
    repeat (3) @(posedge clk);
    #1;
    check("u0_sb_drained", 64'(q0.size()), 0);
    check("u1_sb_drained", 64'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
